// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared IEEE-754 single-precision constants, types and field unpacker
package fp_pkg;
  localparam int EXP_W  = 8;
  localparam int MAN_W  = 23;
  localparam int BIAS   = 127;
  localparam int SIG_W  = MAN_W + 1;
  localparam int ACC_W  = 2 * SIG_W;
  localparam int XEXP_W = EXP_W + 2;
  localparam int CNT_W  = 5;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;

  typedef logic signed [XEXP_W-1:0] xexp_t;

  typedef enum logic [2:0] {IDLE, UNPACK, MULT, NORM, ROUND, DONE} state_t;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] expo;
    logic [MAN_W-1:0] frac;
    logic             is_nan;
    logic             is_inf;
    logic             is_zero;
  } fp_fields_t;

  // A zero exponent field covers both true zeros and subnormals, which are flushed.
  function automatic fp_fields_t fp_unpack(input logic [31:0] w);
    fp_fields_t f;
    f.sign    = w[31];
    f.expo    = w[30:MAN_W];
    f.frac    = w[MAN_W-1:0];
    f.is_nan  = (&f.expo) && (f.frac != '0);
    f.is_inf  = (&f.expo) && (f.frac == '0);
    f.is_zero = (f.expo == '0);
    return f;
  endfunction
endpackage

// File: rtl/fp_round_pack.sv
// rtl/fp_round_pack.sv - round-to-nearest-even and pack a normalised significand into a single word
module fp_round_pack
  import fp_pkg::*;
(
  input  logic [SIG_W-1:0] sig_i,
  input  logic             guard_i,
  input  logic             sticky_i,
  input  xexp_t            exp_i,
  input  logic             sign_i,
  output logic [31:0]      word_o,
  output logic             ovf_o,
  output logic             udf_o
);
  localparam xexp_t EXP_MAX = xexp_t'((1 << EXP_W) - 1);

  logic             round_up;
  logic             carry;
  logic [MAN_W-1:0] man_r;
  xexp_t            exp_r;

  always_comb begin
    round_up = guard_i & (sticky_i | sig_i[0]);
    man_r    = sig_i[MAN_W-1:0] + {{(MAN_W-1){1'b0}}, round_up};
    // An all-ones significand that rounds up becomes 1.0 of the next binade; the fraction wraps to 0.
    carry    = round_up & (&sig_i);
    exp_r    = exp_i + (carry ? xexp_t'(1) : xexp_t'(0));
    ovf_o    = 1'b0;
    udf_o    = 1'b0;
    word_o   = {sign_i, exp_r[EXP_W-1:0], man_r};
    if (exp_r >= EXP_MAX) begin
      word_o = {sign_i, POS_INF[30:0]};
      ovf_o  = 1'b1;
    end else if (exp_r <= xexp_t'(0)) begin
      word_o = {sign_i, 31'b0};
      udf_o  = 1'b1;
    end
  end
endmodule

// File: rtl/floating_point_multiplier_seq.sv
// rtl/floating_point_multiplier_seq.sv - multi-cycle single-precision multiplier with shift-add core
module floating_point_multiplier_seq
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic        underflow,
  output logic        invalid
);
  state_t             state_q, state_d;
  logic [31:0]        a_q, a_d, b_q, b_d;
  logic               sign_q, sign_d;
  xexp_t              exp_q, exp_d;
  logic [ACC_W-1:0]   mcand_q, mcand_d, acc_q, acc_d;
  logic [SIG_W-1:0]   mplier_q, mplier_d, sig_q, sig_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               guard_q, guard_d, sticky_q, sticky_d;
  logic               spec_q, spec_d, spec_inv_q, spec_inv_d;
  logic [31:0]        spec_word_q, spec_word_d, result_q, result_d;
  logic               ovf_q, ovf_d, udf_q, udf_d, inv_q, inv_d;

  fp_fields_t         ua, ub;
  logic               op_sign;
  logic [31:0]        rp_word;
  logic               rp_ovf, rp_udf;

  fp_round_pack u_round_pack (
    .sig_i    (sig_q),
    .guard_i  (guard_q),
    .sticky_i (sticky_q),
    .exp_i    (exp_q),
    .sign_i   (sign_q),
    .word_o   (rp_word),
    .ovf_o    (rp_ovf),
    .udf_o    (rp_udf)
  );

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sign_d      = sign_q;
    exp_d       = exp_q;
    mcand_d     = mcand_q;
    acc_d       = acc_q;
    mplier_d    = mplier_q;
    sig_d       = sig_q;
    cnt_d       = cnt_q;
    guard_d     = guard_q;
    sticky_d    = sticky_q;
    spec_d      = spec_q;
    spec_inv_d  = spec_inv_q;
    spec_word_d = spec_word_q;
    result_d    = result_q;
    ovf_d       = ovf_q;
    udf_d       = udf_q;
    inv_d       = inv_q;
    ua          = fp_unpack(a_q);
    ub          = fp_unpack(b_q);
    op_sign     = ua.sign ^ ub.sign;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          ovf_d   = 1'b0;
          udf_d   = 1'b0;
          inv_d   = 1'b0;
          state_d = UNPACK;
        end
      end
      UNPACK: begin
        sign_d     = op_sign;
        exp_d      = xexp_t'({2'b00, ua.expo}) + xexp_t'({2'b00, ub.expo}) - xexp_t'(BIAS);
        mcand_d    = {{SIG_W{1'b0}}, 1'b1, ua.frac};
        mplier_d   = {1'b1, ub.frac};
        acc_d      = '0;
        cnt_d      = '0;
        spec_d     = 1'b1;
        spec_inv_d = 1'b0;
        if (ua.is_nan || ub.is_nan || (ua.is_inf && ub.is_zero) || (ua.is_zero && ub.is_inf)) begin
          spec_word_d = QNAN;
          spec_inv_d  = 1'b1;
        end else if (ua.is_inf || ub.is_inf) begin
          spec_word_d = {op_sign, POS_INF[30:0]};
        end else if (ua.is_zero || ub.is_zero) begin
          spec_word_d = {op_sign, 31'b0};
        end else begin
          spec_d = 1'b0;
        end
        // Specials bypass the mantissa core and only pass through ROUND to register the word.
        state_d = spec_d ? ROUND : MULT;
      end
      MULT: begin
        acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(SIG_W - 1)) state_d = NORM;
      end
      NORM: begin
        if (acc_q[ACC_W-1]) begin
          sig_d    = acc_q[ACC_W-1 -: SIG_W];
          guard_d  = acc_q[ACC_W-1-SIG_W];
          sticky_d = |acc_q[ACC_W-2-SIG_W:0];
          exp_d    = exp_q + xexp_t'(1);
        end else begin
          sig_d    = acc_q[ACC_W-2 -: SIG_W];
          guard_d  = acc_q[ACC_W-2-SIG_W];
          sticky_d = |acc_q[ACC_W-3-SIG_W:0];
        end
        state_d = ROUND;
      end
      ROUND: begin
        if (spec_q) begin
          result_d = spec_word_q;
          inv_d    = spec_inv_q;
        end else begin
          result_d = rp_word;
          ovf_d    = rp_ovf;
          udf_d    = rp_udf;
        end
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      mcand_q     <= '0;
      acc_q       <= '0;
      mplier_q    <= '0;
      sig_q       <= '0;
      cnt_q       <= '0;
      guard_q     <= 1'b0;
      sticky_q    <= 1'b0;
      spec_q      <= 1'b0;
      spec_inv_q  <= 1'b0;
      spec_word_q <= '0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
      inv_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sign_q      <= sign_d;
      exp_q       <= exp_d;
      mcand_q     <= mcand_d;
      acc_q       <= acc_d;
      mplier_q    <= mplier_d;
      sig_q       <= sig_d;
      cnt_q       <= cnt_d;
      guard_q     <= guard_d;
      sticky_q    <= sticky_d;
      spec_q      <= spec_d;
      spec_inv_q  <= spec_inv_d;
      spec_word_q <= spec_word_d;
      result_q    <= result_d;
      ovf_q       <= ovf_d;
      udf_q       <= udf_d;
      inv_q       <= inv_d;
    end
  end

  assign result    = result_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign overflow  = ovf_q;
  assign underflow = udf_q;
  assign invalid   = inv_q;
endmodule

// File: tb/tb_floating_point_multiplier_seq.sv
// tb/tb_floating_point_multiplier_seq.sv - self-checking bench for the sequential FP multiplier
module tb_floating_point_multiplier_seq;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;
  logic [31:0] result;
  logic        busy, done, overflow, underflow, invalid;

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    logic        udf;
    logic        inv;
    bit          special;
    int          due;
  } exp_t;

  exp_t q[$];
  exp_t cmp_cur;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   n_push = 0;
  int   n_done = 0;

  floating_point_multiplier_seq dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .a         (a_in),
    .b         (b_in),
    .result    (result),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow),
    .underflow (underflow),
    .invalid   (invalid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: exact integer product, then nearest-even rounding via remainder against half-ulp.
  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y);
    exp_t m;
    int ex, ey, e, sh;
    logic s;
    bit nx, ny, ix, iy, zx, zy;
    longint unsigned pa, pb, p, qv, rem, half;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    s  = x[31] ^ y[31];
    nx = (ex == 255) && (x[22:0] != 0);
    ny = (ey == 255) && (y[22:0] != 0);
    ix = (ex == 255) && (x[22:0] == 0);
    iy = (ey == 255) && (y[22:0] == 0);
    zx = (ex == 0);
    zy = (ey == 0);
    m.res = '0; m.ovf = 0; m.udf = 0; m.inv = 0; m.special = 1; m.due = 0;
    if (nx || ny || (ix && zy) || (zx && iy)) begin
      m.res = 32'h7FC00000;
      m.inv = 1;
    end else if (ix || iy) begin
      m.res = {s, 8'hFF, 23'd0};
    end else if (zx || zy) begin
      m.res = {s, 31'd0};
    end else begin
      m.special = 0;
      pa = {1'b1, x[22:0]};
      pb = {1'b1, y[22:0]};
      p  = pa * pb;
      sh = (p >= (64'd1 << 47)) ? 24 : 23;
      e  = ex + ey - 127 + sh - 23;
      qv = p >> sh;
      rem  = p - (qv << sh);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && qv[0])) qv = qv + 1;
      if (qv == (64'd1 << 24)) begin
        qv = qv >> 1;
        e  = e + 1;
      end
      if (e >= 255) begin
        m.res = {s, 8'hFF, 23'd0};
        m.ovf = 1;
      end else if (e <= 0) begin
        m.res = {s, 31'd0};
        m.udf = 1;
      end else begin
        m.res = {s, e[7:0], qv[22:0]};
      end
    end
    return m;
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      chk("busy", busy, q.size() != 0);
      if (done) begin
        if (q.size() == 0) begin
          chk("done_unexpected", done, 1'b0);
        end else begin
          cmp_cur = q.pop_front();
          n_done++;
          chk("done_cycle", cyc, cmp_cur.due);
          chk("result", result, cmp_cur.res);
          chk("flags_ovf_udf_inv", {overflow, underflow, invalid}, {cmp_cur.ovf, cmp_cur.udf, cmp_cur.inv});
        end
      end else if (q.size() != 0 && cyc == q[0].due) begin
        chk("done_missing", done, 1'b1);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy !== 1'b0) chk("idle_timeout", busy, 1'b0);
  endtask

  task automatic issue(input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    wait_idle();
    a_in  = x;
    b_in  = y;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    e     = model(x, y);
    e.due = cyc + (e.special ? 2 : 27);
    q.push_back(e);
    n_push++;
    chk("flags_cleared_on_accept", {overflow, underflow, invalid}, 3'b000);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (q.size() != 0) begin
      chk("done_timeout", q.size(), 0);
      n_push -= q.size();
      q.delete();
    end
  endtask

  task automatic pin(input logic [31:0] x, input logic [31:0] y, input logic [31:0] r, input logic [2:0] f);
    exp_t m;
    m = model(x, y);
    chk("model_pin", {m.res, m.ovf, m.udf, m.inv}, {r, f});
  endtask

  localparam int NDIR = 14;
  logic [31:0] dir_a [NDIR] = '{32'h40100000, 32'hBFC00000, 32'h3F800001, 32'h7F800000, 32'h7F000000,
                                32'h00800000, 32'h7F800001, 32'hFF800000, 32'h80000000, 32'h00000001,
                                32'h3F800001, 32'h3FFFFFFF, 32'hFF000000, 32'h00000000};
  logic [31:0] dir_b [NDIR] = '{32'h3FC00000, 32'h40200000, 32'h3F800001, 32'h00000000, 32'h40000000,
                                32'h3F000000, 32'h3F800000, 32'h40000000, 32'h3F800000, 32'h7F800000,
                                32'h3FFFFFFE, 32'h3FFFFFFF, 32'hC0000000, 32'h80000000};
  logic [31:0] rx, ry;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_result", result, 32'h0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_overflow", overflow, 1'b0);
    chk("reset_underflow", underflow, 1'b0);
    chk("reset_invalid", invalid, 1'b0);
    reset = 1'b1;

    pin(32'h40100000, 32'h3FC00000, 32'h40580000, 3'b000);
    pin(32'hBFC00000, 32'h40200000, 32'hC0700000, 3'b000);
    pin(32'h3F800001, 32'h3F800001, 32'h3F800002, 3'b000);
    pin(32'h7F800000, 32'h00000000, 32'h7FC00000, 3'b001);
    pin(32'h7F000000, 32'h40000000, 32'h7F800000, 3'b100);
    pin(32'h00800000, 32'h3F000000, 32'h00000000, 3'b010);
    pin(32'h3F800001, 32'h3FFFFFFE, 32'h40000000, 3'b000);
    pin(32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 3'b000);

    @(posedge clk); #1;
    for (int i = 0; i < NDIR; i++) begin
      issue(dir_a[i], dir_b[i]);
      drain();
    end

    // Start pulses during an operation and in its DONE cycle must not be accepted.
    begin
      int lat;
      issue(32'hBFC00000, 32'h40200000);
      lat = q[$].due - cyc;
      for (int k = 1; k <= lat; k++) begin
        @(posedge clk); #1;
        a_in  = $urandom;
        b_in  = $urandom;
        start = (k % 2 == 1) || (k == lat);
      end
      @(posedge clk); #1;
      start = 1'b0;
      drain();
      repeat (5) @(posedge clk);
      #1;
      chk("noise_idle_busy", busy, 1'b0);
    end

    // Reset mid-multiply aborts the operation with no done pulse.
    issue(32'h3F800001, 32'h3F800001);
    repeat (11) @(posedge clk);
    #1;
    reset = 1'b0;
    n_push -= q.size();
    q.delete();
    @(posedge clk); #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_result", result, 32'h0);
    reset = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    issue(32'h40100000, 32'h3FC00000);
    drain();

    for (int i = 0; i < 16; i++) begin
      rx = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
      ry = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
      issue(rx, ry);
      drain();
    end

    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    chk("done_count", n_done, n_push);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
